imem_loader: RTL and testbench
==============================

# imem_loader

Serial boot loader that sits directly upstream of the instruction memory and the CPU. It receives a program over a UART line, assembles bytes into 32-bit instruction words, and writes them sequentially into imem through its write port. It holds the CPU in reset until the whole image is written, then releases it so execution starts at PC 0 with the freshly loaded program.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200 baud); minimum 4.
- `ADDR_WIDTH`, default 10: imem word-address width; capacity is 2^ADDR_WIDTH words.
- `clock` input 1: single system clock; all logic rises on this edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rx` input 1: UART serial input, idle high, 8N1, LSB first; asynchronous to `clock`.
- `imem_we` output 1: one-cycle write strobe to imem.
- `imem_addr` output ADDR_WIDTH: word address for the write.
- `imem_wd` output 32: instruction word for the write.
- `cpu_reset` output 1: reset for the mips core; high until the load completes.
- `loading` output 1: high while in LEN_HI, LEN_LO or DATA.
- `done` output 1: image fully written; sticky until `reset`.
- `error` output 1: framing error or bad length; sticky until `reset`.

## Operation
- Reset values: `imem_we`=0, `imem_addr`=0, `imem_wd`=0, `cpu_reset`=1, `loading`=1, `done`=0, `error`=0. The `rx` synchronizer flops reset to 1.
- UART receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit timer. At CLKS_PER_BIT/2 the start bit is re-checked; if it is high, this is a glitch and the receiver returns to idle with no byte.
  - Eight data bits are then sampled at mid-bit, spaced CLKS_PER_BIT apart, followed by the stop bit.
  - Stop bit = 1: `byte_valid` pulses for one cycle with the byte.
  - Stop bit = 0: `frame_err` pulses instead.
- Frame format: 2-byte word count N, big-endian, followed by 4N instruction bytes. Each word is sent big-endian (byte 0 = bits 31:24).
- FSM states: LEN_HI, LEN_LO, DATA, DONE, ERROR.
  - LEN_HI: captures the high count byte, then goes to LEN_LO.
  - LEN_LO: captures the low count byte. If N=0 or N > 2^ADDR_WIDTH, go to ERROR; otherwise go to DATA.
  - DATA: shifts bytes into a 32-bit assembly register and tracks a 2-bit byte counter. On the 4th byte, issues a write; when the word counter reaches N, goes to DONE.
  - DONE and ERROR are terminal until `reset`. All further `rx` traffic is ignored.
- `frame_err` in any non-terminal state forces ERROR. The partial word is discarded and no write is issued.
- `imem_addr` increments after each write and holds the last written address + 1 in DONE.
- `cpu_reset` is 0 only in DONE. In ERROR the CPU stays in reset.

## Timing
- From an `rx` edge to the synchronized edge: 2 cycles.
- `byte_valid` occurs at the stop-bit mid-sample, (9.5 × CLKS_PER_BIT) + 2 cycles after the falling edge of the start bit.
- `imem_we` is high exactly one cycle, on the cycle after the 4th byte's `byte_valid`. `imem_addr` and `imem_wd` are stable during that cycle.
- State becomes DONE on the same edge as the last write. `done`=1 and `cpu_reset`=0 take effect from the cycle after the last `imem_we`.
- Back-to-back bytes with no idle time must be accepted. The receiver re-arms during the stop-bit half-period.
- Asynchronous `reset` mid-byte or mid-word aborts immediately: outputs return to reset values, the partial word is lost, and the FSM restarts in LEN_HI.
- The word counter is ADDR_WIDTH+1 bits so that N = 2^ADDR_WIDTH fits. The final `imem_addr` wraps to 0 when N = 2^ADDR_WIDTH.

## Structure
- Package `loader_types`:
  - `loader_state_t` enum covering LEN_HI, LEN_LO, DATA, DONE, ERROR.
  - `UART_DATA_BITS = 8`, `LEN_BYTES = 2`, `WORD_BYTES = 4`.
- Sub-module `uart_rx`, parameterized by CLKS_PER_BIT.
  - Ports: `clock`, `reset`, `rx` → `byte_valid`, `byte_data[7:0]`, `frame_err`.
  - Contains the synchronizer, bit timer and bit counter.
- The top of `imem_loader` holds the FSM, byte assembly register, byte counter, word counter and address register.
- In `system`, the loader drives the imem write port and the mips `reset` is `reset | cpu_reset`.

## Test plan
(All scenarios use CLKS_PER_BIT=4.)
- N=2, bytes 00 02 20 08 00 05 20 09 00 07 → `imem_we` pulses twice:
  - addr 0, wd 0x20080005;
  - addr 1, wd 0x20090007.
  - Then `done`=1, `cpu_reset`=0, `imem_addr`=2.
- Length 00 00 → ERROR: `error`=1, no `imem_we`, `cpu_reset` stays 1.
- Length 04 01 with ADDR_WIDTH=10 (N=1025) → `error`=1, no writes.
- N=1 and a word whose 3rd byte has stop bit = 0 → `error`=1, no write, subsequent valid bytes ignored.
- 1-cycle low glitch on idle `rx` → no `byte_valid`, state stays LEN_HI.
- Assert `reset` after 6 data bytes of N=2, then resend the full frame → writes start again at addr 0, final `done`=1, both words correct.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial imem boot loader.
// Imported by the receiver and the loader top.
package loader_types;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int LEN_BYTES      = 2;
  localparam int WORD_BYTES     = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Instruction-memory write port driven by the boot loader.
// The loader is the master; imem is the slave.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wd;

  modport master (output we, addr, wd);
  modport slave  (input  we, addr, wd);
endinterface

// File: rtl/imem_loader_uart_rx.sv
// 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Pulses byte_valid or frame_err once per received frame.
module uart_rx
  import loader_types::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    TOP  = 3'(UART_DATA_BITS - 1);

  logic          rx_m;
  logic          rx_s;
  rx_state_t     st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      st         <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (!rx_s) begin
            st  <= RX_START;
            cnt <= CW'(1);
          end
        end
        // a start bit that is high again at mid-bit is a glitch
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            st      <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == TOP) st <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // back to idle at stop mid-bit so the next start is caught
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// UART boot loader: length-prefixed image into imem,
// holds the CPU in reset until the image is written.
module imem_loader
  import loader_types::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rx,
  imem_loader_if.master  imem,
  output logic           cpu_reset,
  output logic           loading,
  output logic           done,
  output logic           error
);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  loader_state_t         state;
  logic [7:0]            len_hi;
  logic [ADDR_WIDTH:0]   n_words;
  logic [ADDR_WIDTH:0]   wcnt;
  logic [1:0]            bcnt;
  logic [31:0]           asm_q;

  logic [15:0]           len_full;
  logic                  len_bad;
  logic [31:0]           word_nxt;
  logic [ADDR_WIDTH:0]   wcnt_nxt;
  logic                  terminal;

  assign len_full = {len_hi, byte_data};
  assign len_bad  = (len_full == 16'd0) ||
                    (32'(len_full) > (32'd1 << ADDR_WIDTH));
  assign word_nxt = {asm_q[23:0], byte_data};
  assign wcnt_nxt = wcnt + 1'b1;
  assign terminal = (state == DONE) || (state == ERROR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LEN_HI;
      len_hi    <= '0;
      n_words   <= '0;
      wcnt      <= '0;
      bcnt      <= '0;
      asm_q     <= '0;
      imem.we   <= 1'b0;
      imem.addr <= '0;
      imem.wd   <= '0;
      cpu_reset <= 1'b1;
      loading   <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      imem.we   <= 1'b0;
      if (imem.we) imem.addr <= imem.addr + 1'b1;
      // status flags trail the state by one cycle
      cpu_reset <= (state != DONE);
      done      <= (state == DONE);
      error     <= (state == ERROR);
      loading   <= !terminal;
      if (frame_err && !terminal) begin
        state <= ERROR;
      end else if (byte_valid) begin
        unique case (state)
          LEN_HI: begin
            len_hi <= byte_data;
            state  <= LEN_LO;
          end
          LEN_LO: begin
            if (len_bad) begin
              state <= ERROR;
            end else begin
              n_words <= (ADDR_WIDTH+1)'(len_full);
              wcnt    <= '0;
              bcnt    <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            asm_q <= word_nxt;
            bcnt  <= bcnt + 1'b1;
            if (bcnt == 2'(WORD_BYTES - 1)) begin
              imem.we <= 1'b1;
              imem.wd <= word_nxt;
              wcnt    <= wcnt_nxt;
              if (wcnt_nxt == n_words) state <= DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a byte-index reference model.
// Directed cases cover bad lengths, framing errors, glitches and reset.
module tb_imem_loader;

  localparam int CPB = 4;
  localparam int AW  = 10;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic cpu_reset, loading, done, error;

  always #5 clock = ~clock;

  imem_loader_if #(.ADDR_WIDTH(AW)) imem ();

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .imem      (imem),
    .cpu_reset (cpu_reset),
    .loading   (loading),
    .done      (done),
    .error     (error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int bv_cnt = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [AW-1:0] ea_q[$];
  logic [31:0]   ed_q[$];
  logic [7:0]    byte_q[$];
  bit            bad_q[$];

  always @(negedge clock) begin
    if (imem.we === 1'b1) begin
      wa_q.push_back(imem.addr);
      wd_q.push_back(imem.wd);
    end
    if (dut.byte_valid === 1'b1) bv_cnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop,
                           input int gap);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = ~bad_stop;
    tick(CPB);
    rx = 1'b1;
    tick(gap);
  endtask

  task automatic push(input logic [7:0] b, input bit bad);
    byte_q.push_back(b);
    bad_q.push_back(bad);
  endtask

  // Expected result derived from byte positions in the stream
  task automatic model(output bit e_done, output bit e_err);
    int n = 0;
    logic [31:0] w = '0;
    e_done = 0;
    e_err  = 0;
    ea_q.delete();
    ed_q.delete();
    for (int i = 0; i < byte_q.size(); i++) begin
      if (e_done || e_err) break;
      if (bad_q[i]) begin
        e_err = 1;
        break;
      end
      if (i == 1) begin
        n = {byte_q[0], byte_q[1]};
        if (n == 0 || n > (1 << AW)) e_err = 1;
      end else if (i >= 2) begin
        int k = i - 2;
        w = {w[23:0], byte_q[i]};
        if (k % 4 == 3) begin
          ea_q.push_back(AW'((k / 4) % (1 << AW)));
          ed_q.push_back(w);
          if (k / 4 + 1 == n) e_done = 1;
        end
      end
    end
  endtask

  task automatic run_stream(input string tag);
    bit e_done, e_err;
    wa_q.delete();
    wd_q.delete();
    for (int i = 0; i < byte_q.size(); i++)
      send_byte(byte_q[i], bad_q[i], $urandom_range(0, 3));
    tick(30);
    model(e_done, e_err);
    check({tag, ".nwr"}, 64'(wa_q.size()), 64'(ea_q.size()));
    for (int i = 0; i < ea_q.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), 64'(wa_q[i]), 64'(ea_q[i]));
      check($sformatf("%s.wd%0d", tag, i), 64'(wd_q[i]), 64'(ed_q[i]));
    end
    check({tag, ".done"}, 64'(done), 64'(e_done));
    check({tag, ".error"}, 64'(error), 64'(e_err));
    check({tag, ".cpu_rst"}, 64'(cpu_reset), 64'(!e_done));
    check({tag, ".loading"}, 64'(loading), 64'(!(e_done || e_err)));
    check({tag, ".addr_end"}, 64'(imem.addr),
          64'(ea_q.size() % (1 << AW)));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".we"}, 64'(imem.we), 64'd0);
    check({tag, ".addr"}, 64'(imem.addr), 64'd0);
    check({tag, ".wd"}, 64'(imem.wd), 64'd0);
    check({tag, ".cpu_rst"}, 64'(cpu_reset), 64'd1);
    check({tag, ".loading"}, 64'(loading), 64'd1);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".error"}, 64'(error), 64'd0);
  endtask

  task automatic load_n2();
    logic [7:0] fr[10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                           8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    byte_q.delete();
    bad_q.delete();
    foreach (fr[i]) push(fr[i], 1'b0);
  endtask

  initial begin
    int bv0;
    do_reset();
    check_reset_vals("rst");

    load_n2();
    run_stream("n2");
    check("n2.wd0_const", 64'(wd_q[0]), 64'h20080005);
    check("n2.wd1_const", 64'(wd_q[1]), 64'h20090007);
    check("n2.addr_const", 64'(imem.addr), 64'd2);

    do_reset();
    byte_q.delete(); bad_q.delete();
    push(8'h00, 0); push(8'h00, 0); push(8'h12, 0); push(8'h34, 0);
    run_stream("len0");

    do_reset();
    byte_q.delete(); bad_q.delete();
    push(8'h04, 0); push(8'h01, 0);
    for (int i = 0; i < 8; i++) push(8'($urandom), 0);
    run_stream("len1025");

    do_reset();
    byte_q.delete(); bad_q.delete();
    push(8'h00, 0); push(8'h01, 0);
    push(8'hde, 0); push(8'had, 0); push(8'hbe, 1); push(8'hef, 0);
    push(8'h00, 0); push(8'h01, 0); push(8'h11, 0); push(8'h22, 0);
    push(8'h33, 0); push(8'h44, 0);
    run_stream("ferr");

    do_reset();
    bv0 = bv_cnt;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    check("glitch.bv", 64'(bv_cnt - bv0), 64'd0);
    check("glitch.loading", 64'(loading), 64'd1);
    byte_q.delete(); bad_q.delete();
    push(8'h00, 0); push(8'h01, 0);
    push(8'hca, 0); push(8'hfe, 0); push(8'hba, 0); push(8'hbe, 0);
    run_stream("glitch");

    do_reset();
    load_n2();
    for (int i = 0; i < 8; i++) send_byte(byte_q[i], 1'b0, 1);
    rx = 1'b0;
    tick(2 * CPB);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    rx = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    run_stream("resend");

    for (int it = 0; it < 5; it++) begin
      int n;
      do_reset();
      byte_q.delete(); bad_q.delete();
      n = $urandom_range(1, 5);
      push(8'(n >> 8), 0);
      push(8'(n), 0);
      for (int i = 0; i < 4 * n; i++) push(8'($urandom), 0);
      push(8'($urandom), 0);
      push(8'($urandom), 0);
      if ($urandom_range(0, 2) == 0)
        bad_q[$urandom_range(0, bad_q.size() - 1)] = 1'b1;
      run_stream($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
